// File: rtl/uart_cobs_rx_pkg.sv
// Shared constants and state encodings for the UART/COBS receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cobs_rx_pkg;

    localparam logic [7:0] COBS_DELIM   = 8'h00;
    localparam logic [7:0] COBS_MAXCODE = 8'hFF;

    typedef enum logic [1:0] {SYNC, CODE, DATA} cobs_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} uart_state_t;

    // Clocks per UART bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser, start recheck at half bit, centre sampling.
// Latency: byte/framing strobe at the stop-bit centre (plus 2-cycle synchroniser delay).
// Backpressure: none; o_strobe / o_ferr are single-cycle pulses the consumer must take.
module uart_rx_8n1
    import uart_cobs_rx_pkg::*;
#(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] o_byte,
    output logic       o_strobe,
    output logic       o_ferr
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    logic              rxd_meta;
    logic              rxd_sync;
    logic              rxd_prev;
    uart_state_t       st;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;

    // Bring rxd into the clock domain; keep one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Bit-timing FSM: a glitch shorter than half a bit is rejected in RX_START.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= RX_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            o_byte   <= '0;
            o_strobe <= 1'b0;
            o_ferr   <= 1'b0;
        end else begin
            o_strobe <= 1'b0;
            o_ferr   <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        st  <= RX_START;
                        cnt <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        st      <= rxd_sync ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (cnt == CNT_W'(DIV - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rxd_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            st <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(DIV - 1)) begin
                        cnt <= '0;
                        st  <= RX_IDLE;
                        if (rxd_sync) begin
                            o_byte   <= shreg;
                            o_strobe <= 1'b1;
                        end else begin
                            o_ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cobs_rx.sv
// UART 8N1 receiver + COBS frame decoder producing a byte stream with sof/eof/err markers.
// Latency: decoded byte 1 cycle after UART byte strobe (one extra byte slot with COBS_CHECKSUM_EN).
// Backpressure: none; every o_valid / o_eof / o_err pulse must be consumed.
// Option COBS_CHECKSUM_EN: trailing byte of each frame is a zero-sum checksum, held back and not emitted.
module uart_cobs_rx
    import uart_cobs_rx_pkg::*;
#(
    parameter  int CLK_HZ  = 27000000,
    parameter  int BAUD    = 115200,
    parameter  int MAX_LEN = 256,
    localparam int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_sof,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_eof,
    output logic             o_err
);

    logic [7:0]       rx_byte;
    logic             rx_strobe;
    logic             rx_ferr;

    cobs_state_t      state;
    logic [7:0]       cnt;
    logic [7:0]       prev_code;
    logic             in_frame;
    logic             ovf;
    logic [IDX_W-1:0] idx;

    logic             dec_vld;
    logic [7:0]       dec_dat;
    logic             frame_close;
    logic             frame_abort;
    logic             emit_vld;
    logic [7:0]       emit_dat;
    logic             close_ok;

`ifdef COBS_CHECKSUM_EN
    logic             hold_vld;
    logic [7:0]       hold_dat;
    logic [7:0]       sum;
`endif

    uart_rx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .o_byte   (rx_byte),
        .o_strobe (rx_strobe),
        .o_ferr   (rx_ferr)
    );

    // Classify the current UART event: decoded byte, clean frame end, or abort.
    always_comb begin
        dec_vld     = 1'b0;
        dec_dat     = rx_byte;
        frame_close = 1'b0;
        frame_abort = 1'b0;
        if (rx_ferr) begin
            frame_abort = in_frame;
        end else if (rx_strobe) begin
            case (state)
                CODE: begin
                    if (rx_byte == COBS_DELIM) begin
                        frame_close = in_frame;
                    end else if (in_frame && prev_code != COBS_MAXCODE) begin
                        // Block boundary inside a frame stands for a zero in the payload.
                        dec_vld = 1'b1;
                        dec_dat = COBS_DELIM;
                    end
                end
                DATA: begin
                    if (rx_byte == COBS_DELIM) begin
                        frame_abort = 1'b1;
                    end else begin
                        dec_vld = 1'b1;
                    end
                end
                default: ;
            endcase
        end
`ifdef COBS_CHECKSUM_EN
        // Each byte is released only once a later decoded byte proves it is not the checksum.
        emit_vld = dec_vld && hold_vld;
        emit_dat = hold_dat;
        close_ok = !ovf && hold_vld && (sum == 8'h00);
`else
        emit_vld = dec_vld;
        emit_dat = dec_dat;
        close_ok = !ovf;
`endif
    end

    // Decoder state, frame bookkeeping and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC;
            cnt       <= '0;
            prev_code <= '0;
            in_frame  <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_sof     <= 1'b0;
            o_idx     <= '0;
            o_eof     <= 1'b0;
            o_err     <= 1'b0;
`ifdef COBS_CHECKSUM_EN
            hold_vld  <= 1'b0;
            hold_dat  <= '0;
            sum       <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_err   <= 1'b0;

            if (emit_vld && !ovf) begin
                o_valid <= 1'b1;
                o_data  <= emit_dat;
                o_idx   <= idx;
                o_sof   <= (idx == '0);
                idx     <= idx + 1'b1;
                if (idx == IDX_W'(MAX_LEN - 1)) begin
                    ovf <= 1'b1;
                end
            end

`ifdef COBS_CHECKSUM_EN
            if (dec_vld) begin
                hold_vld <= 1'b1;
                hold_dat <= dec_dat;
                sum      <= sum + dec_dat;
            end
`endif

            if (frame_close) begin
                o_eof <= close_ok;
                o_err <= !close_ok;
            end
            if (frame_abort) begin
                o_err <= 1'b1;
            end
            if (frame_close || frame_abort) begin
                in_frame <= 1'b0;
                ovf      <= 1'b0;
                idx      <= '0;
`ifdef COBS_CHECKSUM_EN
                hold_vld <= 1'b0;
                sum      <= '0;
`endif
            end

            if (rx_ferr) begin
                state <= SYNC;
            end else if (rx_strobe) begin
                case (state)
                    SYNC: begin
                        if (rx_byte == COBS_DELIM) begin
                            state <= CODE;
                        end
                    end
                    CODE: begin
                        if (rx_byte != COBS_DELIM) begin
                            in_frame  <= 1'b1;
                            cnt       <= rx_byte - 8'd1;
                            prev_code <= rx_byte;
                            state     <= (rx_byte == 8'd1) ? CODE : DATA;
                        end
                    end
                    DATA: begin
                        if (rx_byte == COBS_DELIM) begin
                            state <= SYNC;
                        end else begin
                            cnt <= cnt - 8'd1;
                            if (cnt == 8'd1) begin
                                state <= CODE;
                            end
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

endmodule
